// File: rtl/tfl_pkg.sv
// Shared phase and state encodings plus
// default phase durations for the traffic-light timer.
package tfl_pkg;

  typedef enum logic [1:0] {
    PH_GREEN_A = 2'd0,
    PH_YELLOW  = 2'd1,
    PH_GREEN_B = 2'd2,
    PH_SHORT   = 2'd3
  } phase_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HOLD    = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  localparam int DEF_WIDTH    = 10;
  localparam int DEF_GREEN_A  = 60;
  localparam int DEF_YELLOW   = 5;
  localparam int DEF_GREEN_B  = 50;
  localparam int DEF_SHORT    = 10;
  localparam int DEF_EXT_STEP = 10;
  localparam int DEF_EXT_MAX  = 30;
  localparam int DEF_TICK_DIV = 1;

endpackage

// File: rtl/tick_gen.sv
// Tick prescaler: one tick every TICK_DIV enabled cycles,
// counter zeroed by restart.
module tick_gen #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic enable,
  output logic tick
);

  localparam int CW =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (restart) begin
      cnt_d = '0;
    end else if (enable) begin
      if (cnt_q == LAST) begin
        tick  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/phase_timer.sv
// Phase countdown timer with hold, capped extension
// and a one-cycle done pulse on expiry.
module phase_timer
  import tfl_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int DUR_GREEN_A = DEF_GREEN_A,
  parameter int DUR_YELLOW  = DEF_YELLOW,
  parameter int DUR_GREEN_B = DEF_GREEN_B,
  parameter int DUR_SHORT   = DEF_SHORT,
  parameter int EXT_STEP    = DEF_EXT_STEP,
  parameter int EXT_MAX     = DEF_EXT_MAX,
  parameter int TICK_DIV    = DEF_TICK_DIV
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       phase,
  input  logic             hold,
  input  logic             extend,
  input  logic             clear,
  output logic             done,
  output logic             busy,
  output logic [WIDTH-1:0] remaining,
  output logic [WIDTH-1:0] ext_total
);

  localparam int RMAX = (1 << WIDTH) - 1;

  if (WIDTH < 1 || WIDTH > 30 ||
      DUR_GREEN_A < 1 || DUR_GREEN_A > RMAX ||
      DUR_YELLOW  < 1 || DUR_YELLOW  > RMAX ||
      DUR_GREEN_B < 1 || DUR_GREEN_B > RMAX ||
      DUR_SHORT   < 1 || DUR_SHORT   > RMAX ||
      EXT_MAX < EXT_STEP || EXT_MAX > RMAX ||
      TICK_DIV < 1) begin : g_bad_cfg
    $error("phase_timer: illegal parameters");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] ext_q, ext_d;
  logic             done_q, done_d;

  logic             tick;
  logic             active;
  logic [WIDTH-1:0] dur;
  logic [WIDTH-1:0] room;
  logic [WIDTH-1:0] grant;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] rem_sat;

  assign active = (state_q == ST_RUN) ||
                  (state_q == ST_HOLD);

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .restart(start),
    .enable (active && !hold),
    .tick   (tick)
  );

  always_comb begin
    dur = '0;
    unique case (1'b1)
      phase == PH_GREEN_A: dur = WIDTH'(DUR_GREEN_A);
      phase == PH_YELLOW:  dur = WIDTH'(DUR_YELLOW);
      phase == PH_GREEN_B: dur = WIDTH'(DUR_GREEN_B);
      phase == PH_SHORT:   dur = WIDTH'(DUR_SHORT);
    endcase
  end

  // grant shrinks to whatever is left under the cap
  always_comb begin
    room  = WIDTH'(EXT_MAX) - ext_q;
    grant = '0;
    if (extend) begin
      grant = (room < WIDTH'(EXT_STEP)) ?
              room : WIDTH'(EXT_STEP);
    end
    sum = {1'b0, rem_q} + {1'b0, grant}
        - {{WIDTH{1'b0}}, tick};
    rem_sat = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    ext_d   = ext_q;
    done_d  = 1'b0;
    if (start) begin
      state_d = ST_RUN;
      rem_d   = dur;
      ext_d   = '0;
    end else if (clear) begin
      state_d = ST_IDLE;
      rem_d   = '0;
      ext_d   = '0;
    end else if (active) begin
      state_d = hold ? ST_HOLD : ST_RUN;
      rem_d   = rem_sat;
      ext_d   = ext_q + grant;
      if (tick && rem_sat == '0) begin
        state_d = ST_EXPIRED;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      ext_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      ext_q   <= ext_d;
      done_q  <= done_d;
    end
  end

  assign done      = done_q;
  assign busy      = active;
  assign remaining = rem_q;
  assign ext_total = ext_q;

endmodule

// File: tb/tb_phase_timer.sv
// Random and directed checks of phase_timer against a
// cycle-level arithmetic model; three parameter sets.
module tb_phase_timer;

  logic clk = 1'b0;
  logic reset, start, hold, extend, clear;
  logic [1:0] phase;

  logic done0, done1, done2;
  logic busy0, busy1, busy2;
  logic [9:0] rem0, rem1, ext0, ext1;
  logic [5:0] rem2, ext2;

  int n_cmp = 0;
  int n_bad = 0;

  // model: 0 idle, 1 counting (run or hold), 2 expired
  int m_st[3], m_rem[3], m_ext[3];
  int m_pre[3], m_done[3];
  int td[3] = '{1, 4, 1};
  int rm[3] = '{1023, 1023, 63};

  always #5 clk = ~clk;

  phase_timer #(.TICK_DIV(1)) u_d0 (
    .clk(clk), .reset(reset), .start(start),
    .phase(phase), .hold(hold), .extend(extend),
    .clear(clear), .done(done0), .busy(busy0),
    .remaining(rem0), .ext_total(ext0)
  );

  phase_timer #(.TICK_DIV(4)) u_d1 (
    .clk(clk), .reset(reset), .start(start),
    .phase(phase), .hold(hold), .extend(extend),
    .clear(clear), .done(done1), .busy(busy1),
    .remaining(rem1), .ext_total(ext1)
  );

  phase_timer #(.WIDTH(6), .TICK_DIV(1)) u_d2 (
    .clk(clk), .reset(reset), .start(start),
    .phase(phase), .hold(hold), .extend(extend),
    .clear(clear), .done(done2), .busy(busy2),
    .remaining(rem2), .ext_total(ext2)
  );

  task automatic chk(string tag,
                     logic [31:0] obs,
                     logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d",
               tag, obs, exp);
    end
  endtask

  function automatic int dur_of(int p);
    case (p)
      0: return 60;
      1: return 5;
      2: return 50;
      default: return 10;
    endcase
  endfunction

  function automatic logic [31:0] o_done(int i);
    case (i)
      0: return 32'(done0);
      1: return 32'(done1);
      default: return 32'(done2);
    endcase
  endfunction

  function automatic logic [31:0] o_busy(int i);
    case (i)
      0: return 32'(busy0);
      1: return 32'(busy1);
      default: return 32'(busy2);
    endcase
  endfunction

  function automatic logic [31:0] o_rem(int i);
    case (i)
      0: return 32'(rem0);
      1: return 32'(rem1);
      default: return 32'(rem2);
    endcase
  endfunction

  function automatic logic [31:0] o_ext(int i);
    case (i)
      0: return 32'(ext0);
      1: return 32'(ext1);
      default: return 32'(ext2);
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_st[i] = 0; m_rem[i] = 0; m_ext[i] = 0;
      m_pre[i] = 0; m_done[i] = 0;
    end
  endtask

  task automatic model_step();
    int t, g, r;
    for (int i = 0; i < 3; i++) begin
      m_done[i] = 0;
      if (start) begin
        m_st[i] = 1;
        m_rem[i] = dur_of(int'(phase));
        m_ext[i] = 0;
        m_pre[i] = 0;
      end else if (clear) begin
        m_st[i] = 0; m_rem[i] = 0; m_ext[i] = 0;
      end else if (m_st[i] == 1) begin
        t = 0;
        if (!hold) begin
          m_pre[i]++;
          if (m_pre[i] == td[i]) begin
            t = 1;
            m_pre[i] = 0;
          end
        end
        g = 0;
        if (extend)
          g = (30 - m_ext[i] < 10) ? 30 - m_ext[i] : 10;
        m_ext[i] += g;
        r = m_rem[i] - t + g;
        if (r > rm[i]) r = rm[i];
        m_rem[i] = r;
        if (t == 1 && r == 0) begin
          m_st[i] = 2;
          m_done[i] = 1;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("done%0d", i), o_done(i),
          32'(m_done[i]));
      chk($sformatf("busy%0d", i), o_busy(i),
          32'(m_st[i] == 1));
      chk($sformatf("rem%0d", i), o_rem(i),
          32'(m_rem[i]));
      chk($sformatf("ext%0d", i), o_ext(i),
          32'(m_ext[i]));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic run_until_done(input int idx,
                                input int budget,
                                output int n);
    logic seen;
    seen = 1'b0;
    n = 0;
    for (int k = 0; k < budget; k++) begin
      cyc();
      n++;
      if (o_done(idx) == 32'd1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic kick(input logic [1:0] p);
    phase = p;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got 0 expected 1");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, pulses;
    reset = 1'b0; start = 1'b0; hold = 1'b0;
    extend = 1'b0; clear = 1'b0; phase = 2'd0;
    model_reset();
    #12;
    check_all();
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_rem", 32'(rem0), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) cyc();

    // green-A, TICK_DIV=1
    kick(2'd0);
    chk("ga_load", 32'(rem0), 60);
    run_until_done(0, 200, n);
    chk("ga_lat", 32'(n), 60);
    chk("ga_busy", 32'(busy0), 0);
    cyc();
    chk("ga_done_1cyc", 32'(done0), 0);

    // yellow, TICK_DIV=4
    kick(2'd1);
    run_until_done(1, 200, n);
    chk("y_div4_lat", 32'(n), 20);

    // green-B with 7 cycles of hold
    kick(2'd2);
    repeat (20) cyc();
    hold = 1'b1;
    repeat (7) cyc();
    hold = 1'b0;
    chk("gb_frozen", 32'(rem0), 30);
    run_until_done(0, 200, n);
    chk("gb_hold_lat", 32'(n + 27), 57);

    // short phase with four extend pulses
    kick(2'd3);
    for (int k = 0; k < 4; k++) begin
      extend = 1'b1;
      cyc();
      extend = 1'b0;
      cyc();
    end
    chk("sh_ext_total", 32'(ext0), 30);
    run_until_done(0, 200, n);
    chk("sh_ext_lat", 32'(n + 8), 40);

    // restart mid-run discards the old count
    kick(2'd0);
    repeat (48) cyc();
    chk("pre_restart_rem", 32'(rem0), 12);
    kick(2'd1);
    chk("restart_rem", 32'(rem0), 5);
    chk("restart_done", 32'(done0), 0);

    // async reset mid-run
    kick(2'd0);
    repeat (57) cyc();
    chk("pre_reset_rem", 32'(rem0), 3);
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    chk("arst_rem", 32'(rem0), 0);
    chk("arst_busy", 32'(busy0), 0);
    chk("arst_ext", 32'(ext0), 0);
    check_all();
    @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    repeat (100) begin
      cyc();
      if (done0) pulses++;
    end
    chk("no_done_after_rst", 32'(pulses), 0);

    // randomized traffic
    repeat (3000) begin
      start  = ($urandom_range(0, 49) == 0);
      clear  = ($urandom_range(0, 99) == 0);
      hold   = ($urandom_range(0, 3) == 0);
      extend = ($urandom_range(0, 9) == 0);
      phase  = 2'($urandom_range(0, 3));
      cyc();
      if ($urandom_range(0, 499) == 0) begin
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all();
        #2;
        reset = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/phase_timer.md
PHASE_TIMER -- requirements
Module: phase_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 10, width of the count and remaining-time datapath.
REQ-002 SHALL have parameter DUR_GREEN_A, default 60, green-A phase duration in ticks.
REQ-003 SHALL have parameter DUR_YELLOW, default 5, yellow phase duration in ticks.
REQ-004 SHALL have parameter DUR_GREEN_B, default 50, green-B phase duration in ticks.
REQ-005 SHALL have parameter DUR_SHORT, default 10, short/pedestrian phase duration in ticks.
REQ-006 SHALL have parameter EXT_STEP, default 10, ticks added per extend request.
REQ-007 SHALL have parameter EXT_MAX, default 30, cap on total extension ticks per phase run.
REQ-008 SHALL have parameter TICK_DIV, default 1, clk cycles per tick (1 = every cycle).
REQ-009 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-010 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-011 SHALL have port start, input, 1, loads the duration of phase and begins timing.
REQ-012 SHALL have port phase, input, 2, selects the duration: 0 green-A, 1 yellow, 2 green-B, 3 short.
REQ-013 SHALL have port hold, input, 1, level; freezes the countdown while high.
REQ-014 SHALL have port extend, input, 1, single-cycle request to add EXT_STEP ticks.
REQ-015 SHALL have port clear, input, 1, synchronous abort to IDLE.
REQ-016 SHALL have port done, output, 1, one-cycle pulse when the countdown reaches zero.
REQ-017 SHALL have port busy, output, 1, high in RUN or HOLD.
REQ-018 SHALL have port remaining, output, WIDTH, ticks left in the current phase.
REQ-019 SHALL have port ext_total, output, WIDTH, extension ticks granted in the current run.

Function
REQ-020 SHALL implement FSM states IDLE, RUN, HOLD and EXPIRED.
REQ-021 SHALL give start absolute priority: in any state, load remaining=DUR(phase), clear ext_total, restart the tick prescaler and enter RUN.
REQ-022 SHALL give clear (without start) second priority: go to IDLE, remaining=0, ext_total=0, done=0.
REQ-023 SHALL, in RUN, decrement remaining by 1 on each tick and leave it unchanged otherwise.
REQ-024 SHALL enter EXPIRED when a tick decrements remaining from 1 to 0, with done high for that one cycle only.
REQ-025 SHALL therefore assert done exactly DUR(phase)*TICK_DIV cycles after the start edge, absent hold or extend.
REQ-026 SHALL move RUN->HOLD while hold=1 and HOLD->RUN on hold=0, with the remaining count and prescaler frozen during HOLD.
REQ-027 SHALL accept extend only in RUN or HOLD, granting min(EXT_STEP, EXT_MAX-ext_total) ticks and adding the grant to both remaining and ext_total.
REQ-028 SHALL, when extend and tick coincide, update remaining as remaining-1+grant, with done/EXPIRED only if the result is 0.
REQ-029 SHALL saturate remaining at 2^WIDTH-1 rather than wrap.
REQ-030 SHALL ignore extend and hold in IDLE and EXPIRED.
REQ-031 SHALL keep remaining at 0 in EXPIRED until start or clear.
REQ-032 SHALL cause start during RUN or HOLD to discard the old count with no done pulse.

Reset
REQ-033 SHALL, while reset=0, asynchronously force state=IDLE, remaining=0, ext_total=0, done=0, busy=0 and prescaler=0.
REQ-034 SHALL, on a reset assertion mid-run, abandon the run with no done pulse.
REQ-035 SHALL require a start after reset release before any timing occurs.

Structure
REQ-036 SHALL take the phase encodings (PH_GREEN_A..PH_SHORT), the FSM state encoding and the default durations from shared package tfl_pkg.
REQ-037 SHALL place the prescaler in sub-module tick_gen (params TICK_DIV; ports clk, reset, restart, enable, tick).
REQ-038 SHALL fail elaboration if any duration is 0 or exceeds 2^WIDTH-1, or if EXT_MAX<EXT_STEP.

Verification
REQ-039 SHALL cover: TICK_DIV=1, start phase=0 -> done exactly 60 cycles later, remaining 60..0, busy drops with done.
REQ-040 SHALL cover: TICK_DIV=4, phase=1 -> done exactly 20 cycles after start.
REQ-041 SHALL cover: phase=2 with hold high 7 cycles mid-run -> done delayed by exactly 7 cycles.
REQ-042 SHALL cover: phase=3 with four extend pulses -> ext_total=30 (fourth grants 0) and done at 40 ticks.
REQ-043 SHALL cover: start phase=1 while RUN of phase=0 at remaining=12 -> remaining=5 next cycle with no done pulse.
REQ-044 SHALL cover: reset low at remaining=3 -> all outputs 0 immediately, and no done after release.
